clksplt_n: RTL and testbench
============================

CLKSPLT_N -- requirements
Module: clksplt_n

Interface
REQ-001 The module SHALL have a parameter N_OUT, default 2, giving the number of split outputs (legal 2..16).
REQ-002 The module SHALL have a parameter DELAY, default 2, giving the input-to-output latency in clk cycles (legal 1..8).
REQ-003 The module SHALL have a parameter CT, default 1, giving the critical-timing window in clk cycles (legal 0..7).
REQ-004 Port: clk  input  1  the single clock; all state changes on its rising edge except reset.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: a  input  1  toggle-encoded pulse input; each level change is one pulse.
REQ-007 Port: mode  input  1  0 = broadcast, 1 = round-robin distribution.
REQ-008 Port: en  input  N_OUT  per-output enable mask.
REQ-009 Port: clr_err  input  1  synchronous clear of the sticky error flag and the error counter.
REQ-010 Port: q  output  N_OUT  toggle-encoded pulse outputs.
REQ-011 Port: busy  output  1  high while the critical-timing window is open.
REQ-012 Port: err  output  1  sticky timing-violation flag.
REQ-013 Port: err_cnt  output  8  saturating violation count.

Function
REQ-014 The block SHALL register a each cycle (a_q) and detect a pulse when a differs from a_q at a rising edge.
REQ-015 A pulse detected while the window counter is 0 SHALL be accepted; the counter SHALL load CT on the same edge.
REQ-016 The window counter SHALL decrement by 1 per cycle while nonzero; busy SHALL equal (counter != 0).
REQ-017 A pulse detected while the counter is nonzero SHALL be a violation: the pulse is dropped, the counter is not reloaded, err is set and err_cnt increments (saturating at 255).
REQ-018 With CT = 0 every detected pulse SHALL be accepted and no violation SHALL ever occur.
REQ-019 On acceptance in broadcast mode, the target mask SHALL be en as sampled on the acceptance edge.
REQ-020 On acceptance in round-robin mode, the target SHALL be the lowest enabled index >= ptr, wrapping modulo N_OUT, and ptr SHALL become (target+1) mod N_OUT.
REQ-021 If en is all zero at acceptance, the pulse SHALL still open the window but SHALL produce no output toggle, and ptr SHALL not change.
REQ-022 Each targeted q bit SHALL toggle exactly DELAY cycles after the acceptance edge; non-targeted bits SHALL hold.
REQ-023 Up to DELAY accepted pulses SHALL be in flight at once, each with its own mask, with no loss or reordering.
REQ-024 Changes to mode or en SHALL affect only pulses accepted on or after the edge where they are sampled, never pulses in flight.
REQ-025 If clr_err and a violation occur on the same edge, the violation SHALL win: err = 1 and err_cnt = 1.
REQ-026 If clr_err is asserted alone, err SHALL be 0 and err_cnt SHALL be 0 on the next edge.

Reset
REQ-027 While rst is high, the block SHALL immediately force q = 0, busy = 0, err = 0, err_cnt = 0, a_q = 0, ptr = 0, window counter = 0, and clear all in-flight pulses.
REQ-028 Reset asserted mid-operation SHALL discard in-flight pulses, and no q toggle from them SHALL ever appear.
REQ-029 If a = 1 on the first edge after reset release, that edge SHALL count as a detected pulse.

Verification
REQ-030 Basic latency: N_OUT=2, DELAY=2, CT=1, mode=0, en=11, toggle a once -> q goes 00 to 11 exactly 2 cycles after the detection edge; busy is high for 1 cycle.
REQ-031 Round-robin: N_OUT=4, mode=1, en=1011, 4 pulses spaced 3 cycles apart -> toggles land on q[0], q[1], q[3], q[0] in that order.
REQ-032 Violation: CT=3, second toggle of a 2 cycles after the first -> second pulse dropped, err=1, err_cnt=1, q toggles once only; third pulse after the window closes is accepted.
REQ-033 Pipeline: CT=0, DELAY=4, a toggles on 4 consecutive edges with en changing each cycle -> 4 output toggles on consecutive edges, each applied to its own sampled mask.
REQ-034 Reset mid-flight: DELAY=4, pulse accepted, rst asserted 2 cycles later for 1 cycle -> q = 0 and stays 0; no late toggle appears.
REQ-035 Error clear/saturation: 260 violations -> err_cnt = 255; clr_err coincident with a violation -> err_cnt = 1; clr_err alone -> 0.

Source files
------------

// File: rtl/clksplt_n.sv
// clksplt_n: toggle-pulse splitter with a critical-timing window, broadcast/round-robin fan-out and a fixed delay line
// ports: clk; rst async active-high; a toggle-encoded input; mode 0=broadcast 1=round-robin;
//        en per-output enable; clr_err clears err/err_cnt; q toggle-encoded outputs;
//        busy window open; err sticky violation flag; err_cnt saturating violation count
module clksplt_n #(
  parameter int N_OUT = 2,
  parameter int DELAY = 2,
  parameter int CT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             mode,
  input  logic [N_OUT-1:0] en,
  input  logic             clr_err,
  output logic [N_OUT-1:0] q,
  output logic             busy,
  output logic             err,
  output logic [7:0]       err_cnt
);
  localparam int PW = $clog2(N_OUT);
  logic a_q;
  logic [2:0] cnt;
  logic [PW-1:0] ptr, tgt, idx;
  logic [N_OUT-1:0] mask;
  logic [N_OUT-1:0] pipe [DELAY];
  logic pulse, acc, viol, hit;
  assign pulse = a ^ a_q;
  assign busy = cnt != '0;
  assign acc = pulse && !busy;
  assign viol = pulse && busy;
  // first enabled output at or after ptr, wrapping; hit is low only when en is all zero
  always_comb begin
    tgt = ptr;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N_OUT; i++) begin
      idx = PW'((int'(ptr) + i) % N_OUT);
      if (!hit && en[idx]) begin
        tgt = idx;
        hit = 1'b1;
      end
    end
  end
  assign mask = !hit ? '0 : mode ? N_OUT'(1) << tgt : en;
  // pipe[k] holds the mask accepted k+1 edges ago; the last stage is applied to q
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= 1'b0;
      cnt <= '0;
      ptr <= '0;
      q <= '0;
      err <= 1'b0;
      err_cnt <= '0;
      for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
    end else begin
      a_q <= a;
      cnt <= acc ? 3'(CT) : busy ? cnt - 3'd1 : cnt;
      if (acc && mode && hit) ptr <= tgt == PW'(N_OUT - 1) ? '0 : tgt + 1'b1;
      pipe[0] <= acc ? mask : '0;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
      q <= q ^ pipe[DELAY-1];
      err <= viol | (err & ~clr_err);
      err_cnt <= viol ? (clr_err ? 8'd1 : err_cnt + {7'd0, err_cnt != 8'hff}) : clr_err ? '0 : err_cnt;
    end
endmodule

// File: tb/tb_clksplt_n.sv
// tb_clksplt_n: three clksplt_n configurations on shared stimulus, checked each cycle against an event-level model
module tb_clksplt_n;
  logic clk = 1'b0, rst = 1'b1, a = 1'b0, mode = 1'b0, clr_err = 1'b0;
  logic [3:0] en = 4'hf;
  logic [1:0] q0;
  logic [3:0] q1, q2;
  logic [2:0] busy, err;
  logic [7:0] ec0, ec1, ec2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  clksplt_n #(.N_OUT(2), .DELAY(2), .CT(1)) u0 (.clk(clk), .rst(rst), .a(a), .mode(mode), .en(en[1:0]),
    .clr_err(clr_err), .q(q0), .busy(busy[0]), .err(err[0]), .err_cnt(ec0));
  clksplt_n #(.N_OUT(4), .DELAY(4), .CT(0)) u1 (.clk(clk), .rst(rst), .a(a), .mode(mode), .en(en),
    .clr_err(clr_err), .q(q1), .busy(busy[1]), .err(err[1]), .err_cnt(ec1));
  clksplt_n #(.N_OUT(4), .DELAY(2), .CT(3)) u2 (.clk(clk), .rst(rst), .a(a), .mode(mode), .en(en),
    .clr_err(clr_err), .q(q2), .busy(busy[2]), .err(err[2]), .err_cnt(ec2));

  // model: absolute cycle numbers, last acceptance time, and a schedule of toggle masks by due cycle
  localparam int NO[3] = '{2, 4, 4};
  localparam int DL[3] = '{2, 4, 2};
  localparam int CW[3] = '{1, 0, 3};
  int cyc = 0;
  int last[3], mptr[3], mcnt[3];
  bit [3:0] mq[3];
  bit [3:0] due[3][16];
  bit merr[3], mbusy[3];
  bit ma;
  logic [3:0] pq1 = '0;
  logic [3:0] chg[$];

  function automatic void model_reset();
    ma = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mq[k] = '0; mptr[k] = 0; mcnt[k] = 0; merr[k] = 1'b0; mbusy[k] = 1'b0; last[k] = -100;
      for (int j = 0; j < 16; j++) due[k][j] = '0;
    end
  endfunction

  function automatic void model_step();
    bit pulse, v;
    bit [3:0] ek, m;
    int idx;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    pulse = a != ma;
    ma = a;
    for (int k = 0; k < 3; k++) begin
      mq[k] ^= due[k][cyc % 16];
      due[k][cyc % 16] = '0;
      v = 1'b0;
      if (pulse) begin
        if (cyc - last[k] > CW[k]) begin
          last[k] = cyc;
          ek = en & 4'((1 << NO[k]) - 1);
          m = '0;
          if (ek != 0 && !mode) m = ek;
          else if (ek != 0)
            for (int i = 0; i < NO[k]; i++) begin
              idx = (mptr[k] + i) % NO[k];
              if (m == 0 && ek[idx]) begin
                m = 4'(1 << idx);
                mptr[k] = (idx + 1) % NO[k];
              end
            end
          due[k][(cyc + DL[k]) % 16] |= m;
        end else v = 1'b1;
      end
      if (v) begin
        merr[k] = 1'b1;
        mcnt[k] = clr_err ? 1 : (mcnt[k] < 255 ? mcnt[k] + 1 : 255);
      end else if (clr_err) begin
        merr[k] = 1'b0;
        mcnt[k] = 0;
      end
      mbusy[k] = cyc - last[k] < CW[k];
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] dq[3];
    logic [7:0] dc[3];
    dq = '{{2'b00, q0}, q1, q2};
    dc = '{ec0, ec1, ec2};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.q", k), int'(dq[k]), int'(mq[k]));
      chk($sformatf("u%0d.busy", k), int'(busy[k]), int'(mbusy[k]));
      chk($sformatf("u%0d.err", k), int'(err[k]), int'(merr[k]));
      chk($sformatf("u%0d.err_cnt", k), int'(dc[k]), mcnt[k]);
    end
    if (q1 != pq1) chg.push_back(q1 ^ pq1);
    pq1 = q1;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a = 1'b0;
    model_reset();
    #1 compare_all();
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    tick(2);
    chk("reset u0.q", int'(q0), 0);
    chk("reset u2.busy", int'(busy[2]), 0);
    chk("reset u2.err_cnt", int'(ec2), 0);
    // first edge after release sees a=1: detected pulse, broadcast to 11 two cycles later
    rst = 1'b0;
    a = 1'b1;
    tick(1);
    chk("lat busy1", int'(busy[0]), 1);
    tick(1);
    chk("lat q before", int'(q0), 0);
    chk("lat busy0", int'(busy[0]), 0);
    tick(1);
    chk("lat q after", int'(q0), 3);
    tick(8);
    // round-robin over en=1011 from ptr 0
    chg.delete();
    mode = 1'b1;
    en = 4'b1011;
    repeat (4) begin
      a = ~a;
      tick(3);
    end
    tick(6);
    chk("rr count", chg.size(), 4);
    if (chg.size() == 4) begin
      chk("rr 1st", int'(chg[0]), 4'b0001);
      chk("rr 2nd", int'(chg[1]), 4'b0010);
      chk("rr 3rd", int'(chg[2]), 4'b1000);
      chk("rr 4th", int'(chg[3]), 4'b0001);
    end
    // violation inside a CT=3 window
    do_reset();
    mode = 1'b0;
    en = 4'hf;
    a = 1'b1;
    tick(2);
    a = 1'b0;
    tick(1);
    chk("viol err", int'(err[2]), 1);
    chk("viol cnt", int'(ec2), 1);
    tick(3);
    chk("viol single toggle", int'(q2), 4'hf);
    a = 1'b1;
    tick(1);
    chk("post-window accept busy", int'(busy[2]), 1);
    chk("post-window cnt", int'(ec2), 1);
    tick(3);
    chk("post-window toggle", int'(q2), 0);
    // back-to-back pulses with per-pulse masks
    do_reset();
    chg.delete();
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = 4'(1 << i);
      a = ~a;
      tick(1);
    end
    tick(6);
    chk("pipe count", chg.size(), 4);
    if (chg.size() == 4) begin
      chk("pipe 0", int'(chg[0]), 4'b0001);
      chk("pipe 1", int'(chg[1]), 4'b0010);
      chk("pipe 2", int'(chg[2]), 4'b0100);
      chk("pipe 3", int'(chg[3]), 4'b1000);
    end
    // all-zero enable: no toggle and the round-robin pointer holds
    chg.delete();
    mode = 1'b1;
    en = 4'b0001;
    a = ~a;
    tick(1);
    en = 4'b0000;
    a = ~a;
    tick(1);
    en = 4'b0011;
    a = ~a;
    tick(7);
    chk("en0 count", chg.size(), 2);
    if (chg.size() == 2) begin
      chk("en0 first", int'(chg[0]), 4'b0001);
      chk("en0 second", int'(chg[1]), 4'b0010);
    end
    // reset while a pulse is in flight
    do_reset();
    mode = 1'b0;
    en = 4'hf;
    a = 1'b1;
    tick(2);
    rst = 1'b1;
    a = 1'b0;
    model_reset();
    #1 compare_all();
    chk("midrst q", int'(q1), 0);
    tick(1);
    rst = 1'b0;
    tick(8);
    chk("midrst no late toggle", int'(q1), 0);
    // saturation and clear priority
    do_reset();
    repeat (400) begin
      a = ~a;
      tick(1);
    end
    chk("sat cnt", int'(ec2), 255);
    chk("sat err", int'(err[2]), 1);
    tick(6);
    a = ~a;
    tick(1);
    a = ~a;
    clr_err = 1'b1;
    tick(1);
    chk("clr+viol cnt", int'(ec2), 1);
    chk("clr+viol err", int'(err[2]), 1);
    tick(1);
    chk("clr cnt", int'(ec2), 0);
    chk("clr err", int'(err[2]), 0);
    clr_err = 1'b0;
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
